// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_pkg
// Description : Shared state encoding and parameter-select constants for the
//               masked 2D weighted-order-statistics filter control path.
// Revision    : 1.0 - initial release
// ============================================================================
package filter_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_ARMED  = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Parameter block register selects, also the config word order
  localparam logic [1:0] SEL_N = 2'b00;
  localparam logic [1:0] SEL_H = 2'b01;
  localparam logic [1:0] SEL_W = 2'b10;
  localparam logic [1:0] SEL_R = 2'b11;

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : Row/column position of the pixel being accepted in a
//               raster-scan frame. Column wraps at w-1, row at h-1; last is
//               high while positioned on pixel (h-1, w-1).
// Revision    : 1.0 - initial release
// ============================================================================
module raster_counter
  import filter_pkg::*;
#(
  parameter int INPUT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [INPUT_SIZE-1:0] h,
  input  logic [INPUT_SIZE-1:0] w,
  output logic [INPUT_SIZE-1:0] row,
  output logic [INPUT_SIZE-1:0] col,
  output logic                  last
);

  localparam logic [INPUT_SIZE-1:0] ONE = 1;

  logic w_col_end;
  logic w_row_end;

  // Wrap points come from the frame size, never from counter overflow
  assign w_col_end = (col == (w - ONE));
  assign w_row_end = (row == (h - ONE));
  assign last      = w_col_end & w_row_end;

  // Advance position once per accepted pixel, restart on frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (w_col_end) begin
        col <= '0;
        row <= w_row_end ? '0 : (row + ONE);
      end else begin
        col <= col + ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/filter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : filter_sequencer
// Description : Loads n/h/w/r into the parameter block, validates them on
//               start, then sequences one raster frame of pixels and flags
//               each pixel that completes a (2r+1)x(2r+1) window.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_sequencer
  import filter_pkg::*;
#(
  parameter int INPUT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [INPUT_SIZE-1:0] cfg_data,
  output logic                  cfg_ready,
  output logic [1:0]            par_sel,
  output logic                  par_wen,
  output logic [INPUT_SIZE-1:0] par_data,
  input  logic [INPUT_SIZE-1:0] h,
  input  logic [INPUT_SIZE-1:0] w,
  input  logic [INPUT_SIZE-1:0] r,
  input  logic                  start,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  win_valid,
  output logic [INPUT_SIZE-1:0] ctr_row,
  output logic [INPUT_SIZE-1:0] ctr_col,
  output logic                  frame_done,
  output logic                  cfg_err,
  output logic                  busy
);

  state_t                  state;
  logic [1:0]              cfg_idx;

  logic                    w_cfg_hs;
  logic                    w_pix_hs;
  logic [INPUT_SIZE:0]     w_two_r;
  logic                    w_params_bad;
  logic                    w_win_hit;
  logic                    w_run_go;
  logic [INPUT_SIZE-1:0]   w_row;
  logic [INPUT_SIZE-1:0]   w_col;
  logic                    w_last;

  // Config is accepted everywhere except RUN/DONE; gating with rst_n keeps
  // every output low while reset is held
  assign cfg_ready = rst_n & ((state == ST_IDLE) | (state == ST_CONFIG) |
                              (state == ST_ARMED));
  assign pix_ready = (state == ST_RUN);
  assign busy      = (state == ST_CONFIG) | (state == ST_RUN);

  assign w_cfg_hs  = cfg_valid & cfg_ready;
  assign w_pix_hs  = pix_valid & pix_ready;

  // Word 0 (n) is written from IDLE/ARMED, later words use the running index
  assign par_wen   = w_cfg_hs;
  assign par_sel   = (state == ST_CONFIG) ? cfg_idx : SEL_N;
  assign par_data  = w_cfg_hs ? cfg_data : '0;

  // 2r carries one extra bit so r >= 128 cannot alias to a small value
  assign w_two_r      = {r, 1'b0};
  assign w_params_bad = (h == '0) | (w == '0) |
                        (w_two_r >= {1'b0, h}) | (w_two_r >= {1'b0, w});
  assign w_win_hit    = ({1'b0, w_row} >= w_two_r) & ({1'b0, w_col} >= w_two_r);

  // Config handshake in ARMED takes priority over start
  assign w_run_go = (state == ST_ARMED) & ~w_cfg_hs & start & ~w_params_bad;

  raster_counter #(
    .INPUT_SIZE (INPUT_SIZE)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_run_go),
    .advance (w_pix_hs),
    .h       (h),
    .w       (w),
    .row     (w_row),
    .col     (w_col),
    .last    (w_last)
  );

  // Control FSM with registered window/frame/error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cfg_idx    <= 2'd0;
      win_valid  <= 1'b0;
      ctr_row    <= '0;
      ctr_col    <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (w_cfg_hs) begin
            cfg_idx <= SEL_H;
            state   <= ST_CONFIG;
          end
        end
        ST_CONFIG: begin
          if (w_cfg_hs) begin
            if (cfg_idx == SEL_R) begin
              cfg_idx <= 2'd0;
              state   <= ST_ARMED;
            end else begin
              cfg_idx <= cfg_idx + 2'd1;
            end
          end
        end
        ST_ARMED: begin
          if (w_cfg_hs) begin
            cfg_idx <= SEL_H;
            state   <= ST_CONFIG;
          end else if (start) begin
            if (w_params_bad) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_err <= 1'b0;
              state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_pix_hs) begin
            win_valid <= w_win_hit;
            if (w_win_hit) begin
              ctr_row <= w_row - r;
              ctr_col <= w_col - r;
            end
            if (w_last) begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_ARMED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_filter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_sequencer
// Description : Self-checking bench for filter_sequencer with a behavioural
//               parameter block, a vector table of frame configurations,
//               randomized frames and hand-written reset/priority sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'd0;
  logic       cfg_ready;
  logic [1:0] par_sel;
  logic       par_wen;
  logic [7:0] par_data;
  logic       start = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic       win_valid;
  logic [7:0] ctr_row;
  logic [7:0] ctr_col;
  logic       frame_done;
  logic       cfg_err;
  logic       busy;

  // Parameter block: plain registers, no reset
  logic [7:0] pb_n = 8'd0;
  logic [7:0] pb_h = 8'd0;
  logic [7:0] pb_w = 8'd0;
  logic [7:0] pb_r = 8'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (par_wen) begin
      case (par_sel)
        2'b00:   pb_n <= par_data;
        2'b01:   pb_h <= par_data;
        2'b10:   pb_w <= par_data;
        default: pb_r <= par_data;
      endcase
    end
  end

  filter_sequencer #(.INPUT_SIZE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .par_sel    (par_sel),
    .par_wen    (par_wen),
    .par_data   (par_data),
    .h          (pb_h),
    .w          (pb_w),
    .r          (pb_r),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_valid  (win_valid),
    .ctr_row    (ctr_row),
    .ctr_col    (ctr_col),
    .frame_done (frame_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  int          total = 0;
  int          bad = 0;
  int          nhs = 0;
  int          nfd = 0;
  int          hs_at_fd = 0;
  int          win_at_fd = 0;
  int          fd_prev_hs = 0;
  bit          prev_hs = 1'b0;
  bit          prev_err = 1'b0;
  logic [15:0] got_win[$];
  logic [9:0]  got_par[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observe mid-cycle: inputs are stable, registered outputs settled
  always @(negedge clk) begin
    if (win_valid) begin
      got_win.push_back({ctr_row, ctr_col});
      total++;
      if (!prev_hs) begin
        bad++;
        $display("FAIL win_without_handshake: got win_valid=1 expected 0 at centre (%0d,%0d)",
                 ctr_row, ctr_col);
      end
    end
    if (frame_done) begin
      nfd++;
      hs_at_fd   = nhs;
      win_at_fd  = int'(win_valid);
      fd_prev_hs = int'(prev_hs);
    end
    if (par_wen) got_par.push_back({par_sel, par_data});
    prev_hs = pix_valid & pix_ready;
    if (prev_hs) nhs++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send n,h,w,r; optional idle gaps; optional start raised with word 0
  task automatic load_cfg(input logic [7:0] n, input logic [7:0] hh,
                          input logic [7:0] ww, input logic [7:0] rr,
                          input bit gaps, input bit start_first);
    logic [7:0] words[4];
    words[0] = n; words[1] = hh; words[2] = ww; words[3] = rr;
    got_par.delete();
    for (int i = 0; i < 4; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        cfg_valid = 1'b0;
        tick();
      end
      cfg_valid = 1'b1;
      cfg_data  = words[i];
      start     = (i == 0) && start_first;
      tick();
      start = 1'b0;
      if (i == 0 && start_first) begin
        chk("cfg_beats_start_busy", int'(busy), 1);
        chk("cfg_beats_start_pix_ready", int'(pix_ready), 0);
      end
    end
    cfg_valid = 1'b0;
    chk("par_write_count", got_par.size(), 4);
    for (int i = 0; i < 4 && i < got_par.size(); i++)
      chk("par_write_sel_data", int'(got_par[i]), (i << 8) | int'(words[i]));
    chk("pb_n", int'(pb_n), int'(n));
    chk("pb_h", int'(pb_h), int'(hh));
    chk("pb_w", int'(pb_w), int'(ww));
    chk("pb_r", int'(pb_r), int'(rr));
    chk("armed_busy", int'(busy), 0);
    chk("armed_cfg_ready", int'(cfg_ready), 1);
  endtask

  // Reference: every pixel whose row and column are both at least 2r
  task automatic build_exp(input int hh, input int ww, input int rr);
    exp_q.delete();
    for (int y = 0; y < hh; y++)
      for (int x = 0; x < ww; x++)
        if (y >= 2 * rr && x >= 2 * rr)
          exp_q.push_back({8'(y - rr), 8'(x - rr)});
  endtask

  // mode 0: back-to-back, 1: 1010 valid pattern, 2: random gaps
  task automatic run_frame(input logic [7:0] hh, input logic [7:0] ww,
                           input logic [7:0] rr, input int mode,
                           input bit exp_err, input int exp_wins);
    int npix;
    int k;
    int mism;
    build_exp(int'(hh), int'(ww), int'(rr));
    chk("cfg_err_before_start", int'(cfg_err), int'(prev_err));
    nhs = 0; nfd = 0; hs_at_fd = 0; win_at_fd = 0; fd_prev_hs = 0;
    got_win.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (exp_err) begin
      chk("bad_param_cfg_err", int'(cfg_err), 1);
      chk("bad_param_pix_ready", int'(pix_ready), 0);
      chk("bad_param_busy", int'(busy), 0);
      pix_valid = 1'b1;
      tick();
      tick();
      pix_valid = 1'b0;
      chk("bad_param_no_accept", nhs, 0);
      prev_err = 1'b1;
      return;
    end
    chk("start_cfg_err_clear", int'(cfg_err), 0);
    chk("start_pix_ready", int'(pix_ready), 1);
    chk("start_busy", int'(busy), 1);
    prev_err = 1'b0;
    npix = int'(hh) * int'(ww);
    k = 0;
    while (nhs < npix && k < 8 * npix + 40) begin
      if (mode == 0)      pix_valid = 1'b1;
      else if (mode == 1) pix_valid = (k % 2 == 0);
      else                pix_valid = ($urandom_range(0, 1) == 1);
      tick();
      k++;
    end
    pix_valid = 1'b0;
    tick(); tick(); tick();
    chk("pixels_accepted", nhs, npix);
    chk("frame_done_count", nfd, 1);
    chk("frame_done_after_last", hs_at_fd, npix);
    chk("frame_done_latency", fd_prev_hs, 1);
    chk("last_win_with_frame_done", win_at_fd, 1);
    chk("window_count", got_win.size(), exp_wins);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_win.size() || got_win[i] !== exp_q[i]) mism++;
    chk("centre_sequence_mismatches", mism, 0);
    chk("after_frame_busy", int'(busy), 0);
    chk("after_frame_cfg_ready", int'(cfg_ready), 1);
  endtask

  typedef struct {
    logic [7:0] h;
    logic [7:0] w;
    logic [7:0] r;
    int         mode;
    bit         err;
    int         wins;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] rh;
    logic [7:0] rw;
    logic [7:0] rr;
    bit         rerr;

    tbl[0] = '{8'd5,   8'd6,   8'd1,   0, 1'b0, 12};
    tbl[1] = '{8'd5,   8'd6,   8'd1,   1, 1'b0, 12};
    tbl[2] = '{8'd4,   8'd6,   8'd2,   0, 1'b1, 0};
    tbl[3] = '{8'd4,   8'd6,   8'd1,   2, 1'b0, 8};
    tbl[4] = '{8'd1,   8'd3,   8'd0,   0, 1'b0, 3};
    tbl[5] = '{8'd0,   8'd5,   8'd0,   0, 1'b1, 0};
    tbl[6] = '{8'd7,   8'd7,   8'd3,   2, 1'b0, 1};
    tbl[7] = '{8'd200, 8'd200, 8'd128, 0, 1'b1, 0};
    tbl[8] = '{8'd3,   8'd200, 8'd1,   1, 1'b0, 198};
    tbl[9] = '{8'd8,   8'd4,   8'd1,   2, 1'b0, 12};

    // Reset state
    tick(); tick();
    chk("reset_cfg_ready", int'(cfg_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_win_valid", int'(win_valid), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_cfg_err", int'(cfg_err), 0);
    chk("reset_pix_ready", int'(pix_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_cfg_ready", int'(cfg_ready), 1);

    // start in IDLE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_start_busy", int'(busy), 0);
    chk("idle_start_pix_ready", int'(pix_ready), 0);

    // Table-driven frames
    for (int i = 0; i < 10; i++) begin
      load_cfg(8'd3, tbl[i].h, tbl[i].w, tbl[i].r, (i % 2) == 1, i == 2);
      run_frame(tbl[i].h, tbl[i].w, tbl[i].r, tbl[i].mode, tbl[i].err, tbl[i].wins);
    end

    // Randomized frames against the reference model
    for (int i = 0; i < 8; i++) begin
      rh = 8'($urandom_range(0, 10));
      rw = 8'($urandom_range(0, 10));
      rr = 8'($urandom_range(0, 4));
      rerr = (rh == 0) || (rw == 0) || (2 * int'(rr) >= int'(rh)) ||
             (2 * int'(rr) >= int'(rw));
      build_exp(int'(rh), int'(rw), int'(rr));
      load_cfg(8'($urandom_range(0, 255)), rh, rw, rr, 1'b1, 1'b0);
      run_frame(rh, rw, rr, 2, rerr, rerr ? 0 : exp_q.size());
    end

    // Asynchronous reset mid-frame, right after the pixel completing (1,1)
    load_cfg(8'd3, 8'd5, 8'd6, 8'd1, 1'b0, 1'b0);
    nhs = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 60 && nhs < 15; k++) begin
      pix_valid = 1'b1;
      tick();
    end
    chk("midframe_accepts", nhs, 15);
    chk("midframe_win_valid", int'(win_valid), 1);
    chk("midframe_ctr_row", int'(ctr_row), 1);
    chk("midframe_ctr_col", int'(ctr_col), 1);
    #2;
    rst_n = 1'b0;
    pix_valid = 1'b0;
    #1;
    chk("async_rst_win_valid", int'(win_valid), 0);
    chk("async_rst_ctr_row", int'(ctr_row), 0);
    chk("async_rst_ctr_col", int'(ctr_col), 0);
    chk("async_rst_pix_ready", int'(pix_ready), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_cfg_ready", int'(cfg_ready), 0);
    chk("async_rst_frame_done", int'(frame_done), 0);
    tick();
    rst_n = 1'b1;
    prev_err = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_start_busy", int'(busy), 0);
    chk("post_rst_start_pix_ready", int'(pix_ready), 0);
    chk("post_rst_cfg_err", int'(cfg_err), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/filter_sequencer.md
Name: filter_sequencer

Overview:
- Control block for the masked 2D weighted-order-statistics filter. It loads the four filter parameters (n, h, w, r) into the parameter register block through its sel/w_en/in write port.
- It then sequences one raster-scan frame of pixels with a valid/ready handshake. It tracks row and column position and flags the pixels at which a complete (2r+1)x(2r+1) window is available, emitting the centre coordinates.
- It sits between the host/stream interface and the filter datapath (parameter block, line buffers, rank unit).

Parameters:
- INPUT_SIZE, 8, width of configuration words, parameter values and row/column counters.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config word present on cfg_data
- cfg_data  in  INPUT_SIZE  config word; order n, h, w, r
- cfg_ready  out  1  sequencer accepts config word
- par_sel  out  2  to parameter block sel (00=n, 01=h, 10=w, 11=r)
- par_wen  out  1  to parameter block w_en
- par_data  out  INPUT_SIZE  to parameter block in
- h  in  INPUT_SIZE  image height, read back from parameter block
- w  in  INPUT_SIZE  image width, read back from parameter block
- r  in  INPUT_SIZE  window radius, read back from parameter block
- start  in  1  one-cycle pulse that begins a frame
- pix_valid  in  1  upstream pixel valid
- pix_ready  out  1  sequencer accepts pixel
- win_valid  out  1  registered; window centred at (ctr_row, ctr_col) complete
- ctr_row  out  INPUT_SIZE  window centre row
- ctr_col  out  INPUT_SIZE  window centre column
- frame_done  out  1  one-cycle pulse after last pixel accepted
- cfg_err  out  1  sticky; start refused due to bad parameters
- busy  out  1  high in CONFIG and RUN

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE; all outputs and counters are 0, including cfg_err.
  - Reset mid-CONFIG or mid-RUN abandons the operation. The parameter block (no reset) keeps whatever was already written.
- States: IDLE, CONFIG, ARMED, RUN, DONE.
- IDLE:
  - cfg_ready=1.
  - A cfg_valid handshake writes word 0 (n) and moves to CONFIG with word index 1.
  - start in IDLE is ignored.
- CONFIG:
  - cfg_ready=1.
  - Each accepted word is written combinationally in the same cycle: par_wen=cfg_valid&cfg_ready, par_sel=index, par_data=cfg_data. Index then increments.
  - After index 3 (r) is accepted, go to ARMED on the next edge.
  - No timeout; cfg_valid gaps are allowed.
- ARMED:
  - cfg_ready=1. A new config handshake restarts the load at index 0 (writes n, enters CONFIG).
  - On start, validity is checked:
    - h==0, w==0, 2r>=h or 2r>=w: stay ARMED and set cfg_err.
    - Otherwise clear cfg_err, zero the row/col counters and go to RUN.
  - If start and cfg_valid are high together, config wins and start is dropped.
- RUN:
  - pix_ready=1 and cfg_ready=0.
  - On each pix_valid&pix_ready: col increments. At col==w-1, col wraps to 0 and row increments.
  - Next cycle (1-cycle latency) win_valid=1 if the accepted pixel had row>=2r and col>=2r, with ctr_row=row-r and ctr_col=col-r.
  - Otherwise win_valid=0. win_valid is 0 in every cycle without a handshake.
  - r=0 produces a window at every pixel.
  - Accepting pixel (h-1, w-1) moves to DONE.
  - start in RUN is ignored.
- DONE:
  - Exactly one cycle; frame_done=1 in this cycle.
  - win_valid for the final pixel coincides with frame_done.
  - Returns to ARMED, so the next start reuses the parameters.
- Arithmetic:
  - Comparisons are unsigned on INPUT_SIZE bits; 2r is computed on INPUT_SIZE+1 bits so it cannot overflow.
  - Counter wrap is governed by w/h, never by natural overflow.
- Window count per frame = (h-2r)*(w-2r).
- busy = state in {CONFIG, RUN}.

Decomposition:
- Shared package filter_pkg:
  - state encoding (IDLE=0, CONFIG=1, ARMED=2, RUN=3, DONE=4)
  - parameter select constants SEL_N=00, SEL_H=01, SEL_W=10, SEL_R=11
- One natural sub-module, raster_counter: row/col counters with wrap at w-1/h-1, plus a last-pixel flag. The FSM, config write path and window check stay in filter_sequencer.

Test Plan:
- Config load: send 3,5,6,1 with cfg_valid held -> par_wen high 4 cycles with par_sel 00,01,10,11 and par_data 3,5,6,1; state ARMED afterwards; parameter block reads back n=3, h=5, w=6, r=1.
- Full frame h=5, w=6, r=1: start then 30 back-to-back pixels -> exactly 12 win_valid pulses. First centre (1,1) one cycle after pixel (2,2); last centre (3,4) coincident with frame_done; frame_done exactly once, 1 cycle after the 30th accept.
- Backpressure gaps: same frame with pix_valid toggling 1010… -> identical 12 centres in order; win_valid never in a non-handshake cycle.
- Bad parameters: h=4, w=6, r=2 (2r=4>=h), then start -> stays ARMED, cfg_err=1, no pix_ready. Reload with r=1 and start -> cfg_err=0, RUN.
- Reset mid-frame: deassert rst_n after 10 pixels -> all outputs 0 immediately (asynchronous), state IDLE. Then start with no config -> ignored.
- Edge r=0, h=1, w=3: 3 pixels -> win_valid at every pixel with centres (0,0), (0,1), (0,2), then frame_done.
